cpu_wb_arbiter: RTL and testbench
=================================

CPU_WB_ARBITER -- requirements
Module: cpu_wb_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, maximum consecutive cycles a buffered long-unit result waits before EX is stalled.
REQ-002 clk_in  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ex_we_i / ex_waddr_i / ex_wdata_i  input  1/5/32  single-cycle EX write-back request.
REQ-005 lu_valid_i / lu_waddr_i / lu_wdata_i  input  1/5/32  long-latency unit (load/mul/div) result, valid/ready handshake.
REQ-006 lu_ready_o  output  1  arbiter accepts long-unit result this cycle.
REQ-007 iss_valid_i / iss_rd_i  input  1/5  long op issued; reserves destination rd.
REQ-008 id_raddr1_i / id_raddr2_i  input  5/5  ID source operands.
REQ-009 id_hazard_o  output  1  an ID source register awaits a long-unit result.
REQ-010 ex_stall_o  output  1  EX must hold its current write-back.
REQ-011 we_o / waddr_o / wdata_o  output  1/5/32  register-file write port.

Function
REQ-012 At most one write reaches we_o per cycle; write-port mux is combinational, no added latency.
REQ-013 States: IDLE (buffer empty), HOLD (one buffered long result), FORCE (buffered result granted, EX stalled).
REQ-014 lu_ready_o = 1 in IDLE only; handshake completes when lu_valid_i & lu_ready_o.
REQ-015 IDLE, accept, ex_we_i=0: long result written same cycle; state stays IDLE.
REQ-016 IDLE, accept, ex_we_i=1: EX written; long result captured into buffer; next state HOLD, wait counter = 0.
REQ-017 HOLD, ex_we_i=0: buffer written; next state IDLE.
REQ-018 HOLD, ex_we_i=1: EX written; counter increments; on counter reaching STARVE_MAX-1, next state FORCE.
REQ-019 FORCE: ex_stall_o=1, ex_we_i ignored, buffer written; next state IDLE; ex_stall_o=0 in all other states.
REQ-020 Long result with waddr 0: accepted and discarded, port not used, no state change.
REQ-021 EX write with waddr 0: we_o=0.
REQ-022 Scoreboard: busy[rd] set on iss_valid_i when rd != 0; cleared in the cycle the long result for rd drives we_o.
REQ-023 Same-cycle set and clear of same rd: set wins.
REQ-024 EX writes never clear busy bits; busy[0] always 0.
REQ-025 id_hazard_o = busy[id_raddr1_i] | busy[id_raddr2_i], combinational, uses pre-update busy vector.
REQ-026 Counter is saturating, width ceil(log2(STARVE_MAX))+1; cleared on entry to HOLD.

Reset
REQ-027 rst_n=0 at a clock edge: state IDLE, buffer invalid and contents discarded, counter 0, all busy bits 0, including mid-HOLD/FORCE.
REQ-028 During reset: we_o=0, lu_ready_o=0, ex_stall_o=0, id_hazard_o=0; waddr_o/wdata_o don't-care.

Structure
REQ-029 Shared package cpu_wb_pkg holds state encoding, REG_ADDR_W=5, XLEN=32 and STARVE_MAX default.
REQ-030 Scoreboard is one sub-module cpu_scoreboard (set/clear/lookup ports); FSM, buffer and mux live in cpu_wb_arbiter.

Verification
REQ-031 Idle pass-through: lu_valid_i=1, waddr=5, data=0xA5A5A5A5, ex_we_i=0 -> same cycle we_o=1, waddr_o=5, wdata_o=0xA5A5A5A5, busy[5] cleared.
REQ-032 Collision: lu result x7=0x11 with EX x3=0x22 -> cycle 0 writes x3; lu_ready_o=0 next; next free cycle writes x7=0x11.
REQ-033 Starvation: buffer held, ex_we_i=1 continuously, STARVE_MAX=4 -> ex_stall_o=1 on fourth HOLD/FORCE cycle, buffered write issued, EX write completes next cycle.
REQ-034 Hazard: issue rd=9, ID reads x9 -> id_hazard_o=1 until cycle x9 written; same-cycle reissue of rd=9 keeps id_hazard_o=1.
REQ-035 x0: issue rd=0 and lu result to x0 -> no busy bit set, we_o=0, lu_ready_o stays 1.
REQ-036 Reset in HOLD: rst_n=0 one cycle -> buffered result never written, lu_ready_o=1 after release, id_hazard_o=0.

Source files
------------

// File: rtl/cpu_wb_pkg.sv
// Shared definitions for the CPU write-back arbiter slice.
// Holds the arbiter state encoding, register-file geometry and the default
// starvation limit, plus a small helper to recognise the hard-wired x0.
package cpu_wb_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int XLEN           = 32;
  localparam int STARVE_MAX_DEF = 4;

  // IDLE: buffer empty; HOLD: one long result buffered; FORCE: buffer wins, EX stalled
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_e;

  // Writes to x0 are architecturally discarded
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return (addr == {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Register busy scoreboard.
// Ports: i_set/i_set_addr mark a register as awaiting a long-unit result,
// i_clr/i_clr_addr release it when that result is written, i_raddr1/i_raddr2
// look up the current (pre-update) busy state, o_hit reports either source busy.
// Synchronous active-low reset clears every busy bit.
module cpu_scoreboard
  import cpu_wb_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic                  o_hit
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_next;

  // Set is applied after clear so a re-issue in the same cycle keeps the bit;
  // bit 0 is forced low so x0 can never look busy.
  assign w_set_mask  = (i_set && !is_x0(i_set_addr)) ? ({{(NREG-1){1'b0}}, 1'b1} << i_set_addr)
                                                     : {NREG{1'b0}};
  assign w_clr_mask  = i_clr ? ({{(NREG-1){1'b0}}, 1'b1} << i_clr_addr) : {NREG{1'b0}};
  assign w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~{{(NREG-1){1'b0}}, 1'b1};

  // Lookup uses the registered vector, i.e. the state before this cycle's update
  assign o_hit = r_busy[i_raddr1] | r_busy[i_raddr2];

  // Busy vector register
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Arbitrates the single register-file write port between the one-cycle EX
// write-back and a long-latency unit (load/mul/div).
// Ports: ex_* EX write request; lu_valid_i/lu_ready_o long-unit handshake with
// lu_waddr_i/lu_wdata_i; iss_* reserves a destination at issue; id_raddr* are
// checked against the scoreboard for id_hazard_o; ex_stall_o holds EX while a
// starved buffered result is forced out; we_o/waddr_o/wdata_o drive the port.
// The write mux is combinational so a granted write lands in the same cycle.
module cpu_wb_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  ex_we_i,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]       ex_wdata_i,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_waddr_i,
  input  logic [XLEN-1:0]       lu_wdata_i,
  output logic                  lu_ready_o,
  input  logic                  iss_valid_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_i,
  input  logic [REG_ADDR_W-1:0] id_raddr1_i,
  input  logic [REG_ADDR_W-1:0] id_raddr2_i,
  output logic                  id_hazard_o,
  output logic                  ex_stall_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]       wdata_o
);

  localparam int CNT_W = $clog2(STARVE_MAX) + 1;
  // HOLD moves to FORCE in the cycle the counter steps onto STARVE_MAX-1
  localparam logic [CNT_W-1:0] FORCE_AT = (STARVE_MAX >= 2) ? CNT_W'(STARVE_MAX - 2)
                                                            : {CNT_W{1'b0}};

  wb_state_e             r_state;
  logic [REG_ADDR_W-1:0] r_buf_addr;
  logic [XLEN-1:0]       r_buf_data;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_lu_ready;
  logic                  w_lu_take;
  logic                  w_ex_wr;
  logic                  w_we;
  logic [REG_ADDR_W-1:0] w_waddr;
  logic [XLEN-1:0]       w_wdata;
  logic                  w_stall;
  logic                  w_clr;
  logic                  w_hit;

  // A long result to x0 completes the handshake but is otherwise invisible
  assign w_lu_take = lu_valid_i & w_lu_ready & ~is_x0(lu_waddr_i);
  assign w_ex_wr   = ex_we_i & ~is_x0(ex_waddr_i);

  // Write-port mux and handshake/stall outputs for the current state
  always_comb begin
    w_lu_ready = 1'b0;
    w_we       = 1'b0;
    w_waddr    = ex_waddr_i;
    w_wdata    = ex_wdata_i;
    w_stall    = 1'b0;
    w_clr      = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          w_lu_ready = 1'b1;
          if (lu_valid_i && !is_x0(lu_waddr_i) && !ex_we_i) begin
            w_we    = 1'b1;
            w_waddr = lu_waddr_i;
            w_wdata = lu_wdata_i;
            w_clr   = 1'b1;
          end else begin
            w_we = w_ex_wr;
          end
        end
        ST_HOLD: begin
          if (ex_we_i) begin
            w_we = w_ex_wr;
          end else begin
            w_we    = 1'b1;
            w_waddr = r_buf_addr;
            w_wdata = r_buf_data;
            w_clr   = 1'b1;
          end
        end
        ST_FORCE: begin
          w_stall = 1'b1;
          w_we    = 1'b1;
          w_waddr = r_buf_addr;
          w_wdata = r_buf_data;
          w_clr   = 1'b1;
        end
        default: begin
          w_we = 1'b0;
        end
      endcase
    end else begin
      w_we       = 1'b0;
      w_lu_ready = 1'b0;
      w_stall    = 1'b0;
      w_clr      = 1'b0;
    end
  end

  // Arbiter FSM: buffer capture, starvation counter and state transitions
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_buf_addr <= {REG_ADDR_W{1'b0}};
      r_buf_data <= {XLEN{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lu_take && ex_we_i) begin
            r_buf_addr <= lu_waddr_i;
            r_buf_data <= lu_wdata_i;
            r_cnt      <= {CNT_W{1'b0}};
            r_state    <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!ex_we_i) begin
            r_state <= ST_IDLE;
          end else begin
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt <= r_cnt;
            end
            if (r_cnt >= FORCE_AT) begin
              r_state <= ST_FORCE;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_FORCE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Clear address is the port address: it only matters when a long result is written
  cpu_scoreboard u_scoreboard (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .i_set      (iss_valid_i),
    .i_set_addr (iss_rd_i),
    .i_clr      (w_clr),
    .i_clr_addr (w_waddr),
    .i_raddr1   (id_raddr1_i),
    .i_raddr2   (id_raddr2_i),
    .o_hit      (w_hit)
  );

  assign lu_ready_o  = w_lu_ready;
  assign ex_stall_o  = w_stall;
  assign we_o        = w_we;
  assign waddr_o     = w_waddr;
  assign wdata_o     = w_wdata;
  assign id_hazard_o = rst_n & w_hit;

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Self-checking bench for cpu_wb_arbiter: directed scenarios with constant
// expectations, then randomized traffic against a transaction-level model
// (a queue of waiting long results with an age, plus a busy bit per register).
module tb_cpu_wb_arbiter;

  localparam int SM = 4;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lu_valid_i;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic        lu_ready_o;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  id_raddr1_i;
  logic [4:0]  id_raddr2_i;
  logic        id_hazard_o;
  logic        ex_stall_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  cpu_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .lu_valid_i  (lu_valid_i),
    .lu_waddr_i  (lu_waddr_i),
    .lu_wdata_i  (lu_wdata_i),
    .lu_ready_o  (lu_ready_o),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .id_raddr1_i (id_raddr1_i),
    .id_raddr2_i (id_raddr2_i),
    .id_hazard_o (id_hazard_o),
    .ex_stall_o  (ex_stall_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          age;
  } lr_t;

  lr_t         m_pend[$];
  lr_t         n_pend[$];
  logic [31:0] m_busy = 32'd0;
  logic [31:0] n_busy;
  logic        e_we, e_ready, e_stall, e_haz;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;

  // Expected outputs for the current inputs, and the state after the next edge
  task automatic model_eval();
    int clr;
    lr_t nl;
    clr = -1;
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    e_ready = 1'b0; e_stall = 1'b0; e_haz = 1'b0;
    n_pend = m_pend;
    n_busy = m_busy;
    if (!rst_n) begin
      n_pend.delete();
      n_busy = 32'd0;
    end else begin
      e_ready = (m_pend.size() == 0);
      e_haz   = m_busy[id_raddr1_i] | m_busy[id_raddr2_i];
      if (m_pend.size() != 0) begin
        if (m_pend[0].age >= SM - 1 || !ex_we_i) begin
          e_stall = (m_pend[0].age >= SM - 1);
          e_we = 1'b1; e_wa = m_pend[0].a; e_wd = m_pend[0].d;
          clr = int'(m_pend[0].a);
          n_pend.delete();
        end else begin
          if (ex_waddr_i != 5'd0) begin e_we = 1'b1; e_wa = ex_waddr_i; e_wd = ex_wdata_i; end
          n_pend[0].age = m_pend[0].age + 1;
        end
      end else if (lu_valid_i && lu_waddr_i != 5'd0 && !ex_we_i) begin
        e_we = 1'b1; e_wa = lu_waddr_i; e_wd = lu_wdata_i;
        clr = int'(lu_waddr_i);
      end else begin
        if (ex_we_i && ex_waddr_i != 5'd0) begin e_we = 1'b1; e_wa = ex_waddr_i; e_wd = ex_wdata_i; end
        if (lu_valid_i && lu_waddr_i != 5'd0) begin
          nl.a = lu_waddr_i; nl.d = lu_wdata_i; nl.age = 0;
          n_pend.push_back(nl);
        end
      end
      if (clr >= 0) n_busy[clr] = 1'b0;
      if (iss_valid_i && iss_rd_i != 5'd0) n_busy[iss_rd_i] = 1'b1;
    end
  endtask

  task automatic settle();
    model_eval();
    #3;
  endtask

  task automatic advance();
    @(posedge clk_in);
    m_busy = n_busy;
    m_pend = n_pend;
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1;
    ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    lu_valid_i = 1'b0; lu_waddr_i = 5'd0; lu_wdata_i = 32'd0;
    iss_valid_i = 1'b0; iss_rd_i = 5'd0;
    id_raddr1_i = 5'd0; id_raddr2_i = 5'd0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); rst_n = 1'b0;
      lu_valid_i = 1'b1; lu_waddr_i = 5'd3; lu_wdata_i = 32'h33;
      ex_we_i = 1'b1; ex_waddr_i = 5'd4; iss_valid_i = 1'b1; iss_rd_i = 5'd3; id_raddr1_i = 5'd3;
      settle();
      tests_run++;
      if ({we_o, lu_ready_o, ex_stall_o, id_hazard_o} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_hold: we/ready/stall/haz=%b want 0000", {we_o, lu_ready_o, ex_stall_o, id_hazard_o});
      end
      advance();
    end
    idle_inputs(); id_raddr1_i = 5'd3;
    settle();
    tests_run++;
    if ({we_o, lu_ready_o, ex_stall_o, id_hazard_o} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_release: we/ready/stall/haz=%b want 0100", {we_o, lu_ready_o, ex_stall_o, id_hazard_o});
    end
    advance();
  endtask

  task automatic test_passthrough();
    idle_inputs(); iss_valid_i = 1'b1; iss_rd_i = 5'd5; id_raddr1_i = 5'd5;
    settle();
    tests_run++;
    if (id_hazard_o !== 1'b0) begin
      tests_failed++; $display("FAIL pass_issue_preupdate: haz=%b want 0", id_hazard_o);
    end
    advance();
    idle_inputs(); lu_valid_i = 1'b1; lu_waddr_i = 5'd5; lu_wdata_i = 32'hA5A5A5A5; id_raddr1_i = 5'd5;
    settle();
    tests_run++;
    if ({we_o, waddr_o, wdata_o, lu_ready_o, id_hazard_o} !== {1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL pass_write: we=%b wa=%0d wd=%h rdy=%b haz=%b want 1 5 a5a5a5a5 1 1", we_o, waddr_o, wdata_o, lu_ready_o, id_hazard_o);
    end
    advance();
    idle_inputs(); id_raddr1_i = 5'd5;
    settle();
    tests_run++;
    if ({we_o, id_hazard_o} !== 2'b00) begin
      tests_failed++; $display("FAIL pass_busy_cleared: we=%b haz=%b want 0 0", we_o, id_hazard_o);
    end
    advance();
  endtask

  task automatic test_collision();
    idle_inputs(); lu_valid_i = 1'b1; lu_waddr_i = 5'd7; lu_wdata_i = 32'h11;
    ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h22;
    settle();
    tests_run++;
    if ({we_o, waddr_o, wdata_o, lu_ready_o, ex_stall_o} !== {1'b1, 5'd3, 32'h22, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL coll_ex_first: we=%b wa=%0d wd=%h rdy=%b stall=%b want 1 3 22 1 0", we_o, waddr_o, wdata_o, lu_ready_o, ex_stall_o);
    end
    advance();
    idle_inputs(); ex_we_i = 1'b1; ex_waddr_i = 5'd4; ex_wdata_i = 32'h44;
    settle();
    tests_run++;
    if ({we_o, waddr_o, wdata_o, lu_ready_o, ex_stall_o} !== {1'b1, 5'd4, 32'h44, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL coll_hold_ex: we=%b wa=%0d wd=%h rdy=%b stall=%b want 1 4 44 0 0", we_o, waddr_o, wdata_o, lu_ready_o, ex_stall_o);
    end
    advance();
    idle_inputs();
    settle();
    tests_run++;
    if ({we_o, waddr_o, wdata_o, lu_ready_o} !== {1'b1, 5'd7, 32'h11, 1'b0}) begin
      tests_failed++;
      $display("FAIL coll_drain: we=%b wa=%0d wd=%h rdy=%b want 1 7 11 0", we_o, waddr_o, wdata_o, lu_ready_o);
    end
    advance();
    idle_inputs();
    settle();
    tests_run++;
    if ({we_o, lu_ready_o} !== 2'b01) begin
      tests_failed++; $display("FAIL coll_back_idle: we=%b rdy=%b want 0 1", we_o, lu_ready_o);
    end
    advance();
  endtask

  task automatic test_starvation();
    idle_inputs(); lu_valid_i = 1'b1; lu_waddr_i = 5'd12; lu_wdata_i = 32'hC0DE;
    ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h100;
    settle();
    tests_run++;
    if ({we_o, waddr_o, lu_ready_o} !== {1'b1, 5'd1, 1'b1}) begin
      tests_failed++; $display("FAIL starve_entry: we=%b wa=%0d rdy=%b want 1 1 1", we_o, waddr_o, lu_ready_o);
    end
    advance();
    for (int i = 1; i <= 3; i++) begin
      idle_inputs(); ex_we_i = 1'b1; ex_waddr_i = 5'(i + 1); ex_wdata_i = 32'(i);
      settle();
      tests_run++;
      if ({we_o, waddr_o, wdata_o, ex_stall_o, lu_ready_o} !== {1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL starve_hold%0d: we=%b wa=%0d wd=%h stall=%b rdy=%b", i, we_o, waddr_o, wdata_o, ex_stall_o, lu_ready_o);
      end
      advance();
    end
    idle_inputs(); ex_we_i = 1'b1; ex_waddr_i = 5'd8; ex_wdata_i = 32'h800;
    settle();
    tests_run++;
    if ({we_o, waddr_o, wdata_o, ex_stall_o, lu_ready_o} !== {1'b1, 5'd12, 32'hC0DE, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL starve_force: we=%b wa=%0d wd=%h stall=%b rdy=%b want 1 12 c0de 1 0", we_o, waddr_o, wdata_o, ex_stall_o, lu_ready_o);
    end
    advance();
    settle();
    tests_run++;
    if ({we_o, waddr_o, wdata_o, ex_stall_o, lu_ready_o} !== {1'b1, 5'd8, 32'h800, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL starve_ex_done: we=%b wa=%0d wd=%h stall=%b rdy=%b want 1 8 800 0 1", we_o, waddr_o, wdata_o, ex_stall_o, lu_ready_o);
    end
    advance();
  endtask

  task automatic test_hazard();
    idle_inputs(); iss_valid_i = 1'b1; iss_rd_i = 5'd9; id_raddr1_i = 5'd9;
    settle();
    tests_run++;
    if (id_hazard_o !== 1'b0) begin tests_failed++; $display("FAIL haz_issue: haz=%b want 0", id_hazard_o); end
    advance();
    idle_inputs(); id_raddr2_i = 5'd9;
    settle();
    tests_run++;
    if (id_hazard_o !== 1'b1) begin tests_failed++; $display("FAIL haz_src2: haz=%b want 1", id_hazard_o); end
    advance();
    idle_inputs(); id_raddr1_i = 5'd9; lu_valid_i = 1'b1; lu_waddr_i = 5'd9; lu_wdata_i = 32'h99;
    iss_valid_i = 1'b1; iss_rd_i = 5'd9;
    settle();
    tests_run++;
    if ({id_hazard_o, we_o, waddr_o} !== {1'b1, 1'b1, 5'd9}) begin
      tests_failed++; $display("FAIL haz_write_reissue: haz=%b we=%b wa=%0d want 1 1 9", id_hazard_o, we_o, waddr_o);
    end
    advance();
    idle_inputs(); id_raddr1_i = 5'd9;
    settle();
    tests_run++;
    if (id_hazard_o !== 1'b1) begin tests_failed++; $display("FAIL haz_set_wins: haz=%b want 1", id_hazard_o); end
    advance();
    idle_inputs(); id_raddr1_i = 5'd9; lu_valid_i = 1'b1; lu_waddr_i = 5'd9; lu_wdata_i = 32'h98;
    settle();
    advance();
    idle_inputs(); id_raddr1_i = 5'd9;
    settle();
    tests_run++;
    if (id_hazard_o !== 1'b0) begin tests_failed++; $display("FAIL haz_cleared: haz=%b want 0", id_hazard_o); end
    advance();
  endtask

  task automatic test_x0();
    idle_inputs(); iss_valid_i = 1'b1; iss_rd_i = 5'd0; lu_valid_i = 1'b1; lu_waddr_i = 5'd0; lu_wdata_i = 32'hDEAD;
    settle();
    tests_run++;
    if ({we_o, lu_ready_o, id_hazard_o} !== 3'b010) begin
      tests_failed++; $display("FAIL x0_lu: we/rdy/haz=%b want 010", {we_o, lu_ready_o, id_hazard_o});
    end
    advance();
    idle_inputs(); ex_we_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h1;
    settle();
    tests_run++;
    if ({we_o, lu_ready_o, id_hazard_o} !== 3'b010) begin
      tests_failed++; $display("FAIL x0_ex: we/rdy/haz=%b want 010", {we_o, lu_ready_o, id_hazard_o});
    end
    advance();
    idle_inputs(); lu_valid_i = 1'b1; lu_waddr_i = 5'd0; ex_we_i = 1'b1; ex_waddr_i = 5'd2; ex_wdata_i = 32'h2;
    settle();
    advance();
    idle_inputs();
    settle();
    tests_run++;
    if ({we_o, lu_ready_o} !== 2'b01) begin
      tests_failed++; $display("FAIL x0_no_buffer: we=%b rdy=%b want 0 1", we_o, lu_ready_o);
    end
    advance();
  endtask

  task automatic test_reset_in_hold();
    idle_inputs(); iss_valid_i = 1'b1; iss_rd_i = 5'd20;
    settle(); advance();
    idle_inputs(); lu_valid_i = 1'b1; lu_waddr_i = 5'd20; lu_wdata_i = 32'h2020;
    ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h1;
    settle(); advance();
    idle_inputs(); rst_n = 1'b0; id_raddr1_i = 5'd20;
    settle();
    tests_run++;
    if ({we_o, lu_ready_o, ex_stall_o, id_hazard_o} !== 4'b0000) begin
      tests_failed++; $display("FAIL rsthold_during: we/rdy/stall/haz=%b want 0000", {we_o, lu_ready_o, ex_stall_o, id_hazard_o});
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); id_raddr1_i = 5'd20;
      settle();
      tests_run++;
      if ({we_o, lu_ready_o, ex_stall_o, id_hazard_o} !== 4'b0100) begin
        tests_failed++; $display("FAIL rsthold_after%0d: we/rdy/stall/haz=%b want 0100", i, {we_o, lu_ready_o, ex_stall_o, id_hazard_o});
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      ex_we_i     = ($urandom_range(0, 2) != 0);
      ex_waddr_i  = 5'($urandom_range(0, 7));
      ex_wdata_i  = $urandom;
      lu_valid_i  = ($urandom_range(0, 1) != 0);
      lu_waddr_i  = 5'($urandom_range(0, 7));
      lu_wdata_i  = $urandom;
      iss_valid_i = ($urandom_range(0, 2) == 0);
      iss_rd_i    = 5'($urandom_range(0, 7));
      id_raddr1_i = 5'($urandom_range(0, 7));
      id_raddr2_i = 5'($urandom_range(0, 7));
      settle();
      tests_run++;
      if ({lu_ready_o, ex_stall_o, id_hazard_o, we_o} !== {e_ready, e_stall, e_haz, e_we} ||
          (e_we && {waddr_o, wdata_o} !== {e_wa, e_wd})) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: rdy/stall/haz/we=%b wa=%0d wd=%h, want %b wa=%0d wd=%h", n,
                 {lu_ready_o, ex_stall_o, id_hazard_o, we_o}, waddr_o, wdata_o,
                 {e_ready, e_stall, e_haz, e_we}, e_wa, e_wd);
      end
      advance();
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk_in);
    #1;
    test_reset();
    test_passthrough();
    test_collision();
    test_starvation();
    test_hazard();
    test_x0();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
